// File: rtl/fib_seq_gen_if.sv
// Request/response bundle for the Fibonacci sequence generator.
// The master drives start_in/n_in; the slave returns the emitted terms and status flags.
interface fib_seq_gen_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 5
);

  logic                   start_in;
  logic [COUNT_WIDTH-1:0] n_in;
  logic [DATA_WIDTH-1:0]  term_out;
  logic                   term_valid_out;
  logic                   busy_out;
  logic                   done_out;
  logic                   overflow_out;
  logic [DATA_WIDTH-1:0]  led_out;

  modport master (
    output start_in,
    output n_in,
    input  term_out,
    input  term_valid_out,
    input  busy_out,
    input  done_out,
    input  overflow_out,
    input  led_out
  );

  modport slave (
    input  start_in,
    input  n_in,
    output term_out,
    output term_valid_out,
    output busy_out,
    output done_out,
    output overflow_out,
    output led_out
  );

endinterface

// File: rtl/fib_seq_gen.sv
// Emits F(0)..F(n-1) mod 2^DATA_WIDTH, one term every TICK_DIV cycles, with a sticky wrap flag.
// Every output is registered.
module fib_seq_gen #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 5,
  parameter int unsigned TICK_DIV    = 1
) (
  input  logic          clock_in,
  input  logic          reset_in,
  fib_seq_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StWait,
    StDone
  } state_e;

  // WAIT spans TICK_DIV-1 cycles: the counter runs from TICK_DIV-2 down to 0.
  localparam logic [15:0] WaitLoad = (TICK_DIV > 1) ? 16'(TICK_DIV - 2) : 16'd0;

  state_e                 r_state;
  logic [DATA_WIDTH-1:0]  r_a;
  logic [DATA_WIDTH-1:0]  r_b;
  logic                   r_a_tag;
  logic                   r_b_tag;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [15:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0]  r_term;
  logic [DATA_WIDTH-1:0]  r_led;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;

  logic [DATA_WIDTH:0]    w_sum;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_a_tag     <= 1'b0;
      r_b_tag     <= 1'b0;
      r_remaining <= '0;
      r_wait_cnt  <= '0;
      r_term      <= '0;
      r_led       <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_busy <= 1'b0;
          if (bus.start_in) begin
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
            if (bus.n_in != '0) begin
              r_a         <= '0;
              r_b         <= DATA_WIDTH'(1);
              r_a_tag     <= 1'b0;
              r_b_tag     <= 1'b0;
              r_remaining <= bus.n_in;
              r_state     <= StEmit;
            end else begin
              r_state <= StDone;
            end
          end
        end

        StEmit: begin
          r_term      <= r_a;
          r_led       <= r_a;
          r_valid     <= 1'b1;
          r_remaining <= r_remaining - COUNT_WIDTH'(1);
          if (r_a_tag) begin
            r_overflow <= 1'b1;
          end
          // A wrap anywhere in the ancestry taints every later term.
          r_a     <= r_b;
          r_a_tag <= r_b_tag;
          r_b     <= w_sum[DATA_WIDTH-1:0];
          r_b_tag <= w_sum[DATA_WIDTH] | r_a_tag | r_b_tag;
          if (r_remaining == COUNT_WIDTH'(1)) begin
            r_state <= StDone;
          end else if (TICK_DIV == 1) begin
            r_state <= StEmit;
          end else begin
            r_wait_cnt <= WaitLoad;
            r_state    <= StWait;
          end
        end

        StWait: begin
          if (r_wait_cnt == '0) begin
            r_state <= StEmit;
          end else begin
            r_wait_cnt <= r_wait_cnt - 16'd1;
          end
        end

        StDone: begin
          r_done  <= 1'b1;
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.term_out       = r_term;
  assign bus.led_out        = r_led;
  assign bus.term_valid_out = r_valid;
  assign bus.busy_out       = r_busy;
  assign bus.done_out       = r_done;
  assign bus.overflow_out   = r_overflow;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Randomized and directed bench for fib_seq_gen with TICK_DIV=1 and TICK_DIV=4 instances.
// Expected timelines come from a term/offset model built on plain Fibonacci arithmetic.
module tb_fib_seq_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic rst1;
  logic rst4;

  always #5 clk = ~clk;

  fib_seq_gen_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus1 ();
  fib_seq_gen_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus4 ();

  fib_seq_gen #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TICK_DIV(1)) u_dut1 (
    .clock_in (clk),
    .reset_in (rst1),
    .bus      (bus1)
  );

  fib_seq_gen #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TICK_DIV(4)) u_dut4 (
    .clock_in (clk),
    .reset_in (rst4),
    .bus      (bus4)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] prev_term [2];
  logic          prev_ovf  [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint fib(input int k);
    longint a = 0;
    longint b = 1;
    longint t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic drive(input int sel, input logic start, input logic [CW-1:0] n);
    if (sel == 1) begin
      bus4.start_in = start;
      bus4.n_in     = n;
    end else begin
      bus1.start_in = start;
      bus1.n_in     = n;
    end
  endtask

  task automatic check_outputs(input int sel, input logic [DW-1:0] term, input logic valid,
                               input logic busy, input logic done, input logic ovf);
    if (sel == 1) begin
      check_eq("t4_term", 32'(bus4.term_out), 32'(term));
      check_eq("t4_led", 32'(bus4.led_out), 32'(term));
      check_eq("t4_valid", 32'(bus4.term_valid_out), 32'(valid));
      check_eq("t4_busy", 32'(bus4.busy_out), 32'(busy));
      check_eq("t4_done", 32'(bus4.done_out), 32'(done));
      check_eq("t4_ovf", 32'(bus4.overflow_out), 32'(ovf));
    end else begin
      check_eq("t1_term", 32'(bus1.term_out), 32'(term));
      check_eq("t1_led", 32'(bus1.led_out), 32'(term));
      check_eq("t1_valid", 32'(bus1.term_valid_out), 32'(valid));
      check_eq("t1_busy", 32'(bus1.busy_out), 32'(busy));
      check_eq("t1_done", 32'(bus1.done_out), 32'(done));
      check_eq("t1_ovf", 32'(bus1.overflow_out), 32'(ovf));
    end
  endtask

  // Offsets count rising edges after the edge that samples start_in.
  task automatic run_seq(input int sel, input int n, input bit hold, input int stop_off);
    int            tick;
    int            done_off;
    int            last;
    int            j;
    logic [DW-1:0] exp_term;
    logic          exp_ovf;
    logic          exp_valid;
    tick     = (sel == 1) ? 4 : 1;
    done_off = (n == 0) ? 2 : (n - 1) * tick + 3;
    last     = (stop_off > 0) ? stop_off : done_off;
    exp_term = prev_term[sel];
    exp_ovf  = 1'b0;
    drive(sel, 1'b1, CW'(n));
    for (int off = 1; off <= last; off++) begin
      @(posedge clk);
      #1;
      if (!hold) drive(sel, 1'b0, CW'($urandom));
      exp_valid = 1'b0;
      if (n > 0 && off >= 2 && ((off - 2) % tick) == 0 && ((off - 2) / tick) < n) begin
        j         = (off - 2) / tick;
        exp_valid = 1'b1;
        exp_term  = DW'(fib(j));
        if (fib(j) >= (longint'(1) << DW)) exp_ovf = 1'b1;
      end
      check_outputs(sel, exp_term, exp_valid, 1'b1, off == done_off, exp_ovf);
    end
    prev_term[sel] = exp_term;
    prev_ovf[sel]  = exp_ovf;
  endtask

  task automatic idle_check(input int sel, input int cycles);
    drive(sel, 1'b0, CW'($urandom));
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      check_outputs(sel, prev_term[sel], 1'b0, 1'b0, 1'b0, prev_ovf[sel]);
    end
  endtask

  task automatic set_reset(input int sel, input logic v);
    if (sel == 1) rst4 = v;
    else          rst1 = v;
  endtask

  // Reset lands after the third term is visible; nothing may complete afterwards.
  task automatic abort_run(input int sel, input int n);
    int tick;
    tick = (sel == 1) ? 4 : 1;
    run_seq(sel, n, 1'b0, 2 + 2 * tick);
    set_reset(sel, 1'b1);
    @(posedge clk);
    #1;
    set_reset(sel, 1'b0);
    prev_term[sel] = '0;
    prev_ovf[sel]  = 1'b0;
    check_outputs(sel, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check(sel, n * tick + 3);
  endtask

  initial begin
    int sel;
    int n;
    rst1 = 1'b1;
    rst4 = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    prev_term[0] = '0;
    prev_term[1] = '0;
    prev_ovf[0]  = 1'b0;
    prev_ovf[1]  = 1'b0;
    check_outputs(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outputs(1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst1 = 1'b0;
    rst4 = 1'b0;
    idle_check(0, 2);

    run_seq(0, 7, 1'b0, 0);
    idle_check(0, 2);
    run_seq(0, 15, 1'b0, 0);
    idle_check(0, 3);
    run_seq(0, 0, 1'b0, 0);
    idle_check(0, 2);
    run_seq(1, 3, 1'b0, 0);
    idle_check(1, 2);
    run_seq(1, 0, 1'b0, 0);
    idle_check(1, 2);

    // start_in held high: each run only restarts once back in IDLE.
    run_seq(0, 15, 1'b1, 0);
    run_seq(0, 4, 1'b1, 0);
    run_seq(0, 2, 1'b0, 0);
    idle_check(0, 2);
    run_seq(1, 2, 1'b1, 0);
    run_seq(1, 3, 1'b0, 0);
    idle_check(1, 2);

    abort_run(0, 10);
    run_seq(0, 5, 1'b0, 0);
    idle_check(0, 1);
    abort_run(1, 10);
    run_seq(1, 4, 1'b0, 0);
    idle_check(1, 1);

    // Reset wins over a simultaneous start.
    drive(0, 1'b1, CW'(5));
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    prev_term[0] = '0;
    prev_ovf[0]  = 1'b0;
    check_outputs(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check(0, 3);

    repeat (40) begin
      sel = int'($urandom % 2);
      n   = int'($urandom_range(0, 31));
      if (($urandom % 4) == 0) begin
        run_seq(sel, n, 1'b1, 0);
        run_seq(sel, int'($urandom_range(0, 20)), 1'b0, 0);
      end else begin
        run_seq(sel, n, 1'b0, 0);
      end
      idle_check(sel, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
